note_sequencer: RTL and testbench
=================================

# note_sequencer

Fetches 16-bit score words from external RAM through a request/acknowledge port, prefetches them into a 2-entry buffer, and plays them out one note at a time to the timing controller. It consumes BPM commands internally and owns play/pause and end-of-song handling. It sits between the memory controller's data port and the timing/tone blocks, replacing the button-driven word stepping.

## Interface
- `ADDR_W`, default 23: word-address width.
- `START_ADDR`, default 0: first score word address.
- `BPM_DEFAULT`, default 80: BPM after reset and after song end.
- `CLK` in, 1 bit: 100 MHz clock.
- `RST` in, 1 bit: reset, asynchronous, active-high.
- `PLAY_TOGGLE` in, 1 bit: one-cycle pulse (debounced upstream); toggles play/pause.
- `MEM_REQ` out, 1 bit: word read request.
- `MEM_ADDR` out, `ADDR_W` bits: word address, valid while `MEM_REQ`.
- `MEM_ACK` in, 1 bit: one-cycle pulse; `MEM_DATA` valid that cycle.
- `MEM_DATA` in, 16 bits: score word.
- `NOTE_DONE` in, 1 bit: one-cycle pulse from the timing controller, current note finished.
- `NOTE_VALID` out, 1 bit: `MODE`/`TONE`/`NOTE` hold a note to play.
- `MODE` out, 2 bits; `TONE` out, 6 bits; `NOTE` out, 4 bits: decoded current note.
- `BPM` out, 8 bits: current tempo.
- `PLAYING` out, 1 bit: play state.
- `SONG_END` out, 1 bit: one-cycle pulse on end marker.

## Operation
- Word format:
  - [15:14] mode: 00 NORMAL, 01 STACCATO, 10 SLURRED, 11 BPM_COMM.
  - [13:8] tone; [3:0] note duration.
  - For BPM_COMM, [7:0] is the new BPM.
  - BPM_COMM with [7:0]=0 (16'hC000) is the end marker.
- Fetch FSM, states F_IDLE and F_WAIT:
  - F_IDLE→F_WAIT when buffer has a free slot and no end marker is buffered. Set `MEM_REQ`=1 and present the address counter.
  - F_WAIT holds `MEM_REQ` and `MEM_ADDR` stable until `MEM_ACK`.
  - On `MEM_ACK`: push `MEM_DATA`, increment the address (wraps 2^`ADDR_W`-1→0), return to F_IDLE.
  - Prefetch runs whether playing or paused.
- Playout FSM, states P_STOP, P_RUN, P_PAUSE:
  - P_STOP→P_RUN on `PLAY_TOGGLE`.
  - In P_RUN, a pop is needed at entry and on `NOTE_DONE`.
  - Pop of a note word: drives `MODE`/`TONE`/`NOTE`, `NOTE_VALID`=1.
  - Pop of BPM_COMM (nonzero): `BPM`←[7:0], then pop again next cycle. No note time is consumed.
  - Pop of end marker:
    - `SONG_END` pulses, `NOTE_VALID`=0, `BPM`←`BPM_DEFAULT`.
    - Buffer is flushed; an in-flight fetch completes but its data is discarded.
    - Address←`START_ADDR`; go to P_STOP.
  - Buffer empty when a pop is needed (underflow): `NOTE_VALID`=0. Pop on the first push.
  - P_RUN→P_PAUSE on `PLAY_TOGGLE`: `NOTE_VALID`=0, current note retained.
  - P_PAUSE→P_RUN on `PLAY_TOGGLE`: `NOTE_VALID`=1 with the same note (restarted, not advanced).
- `PLAYING`=1 only in P_RUN.
- Simultaneous events:
  - `PLAY_TOGGLE` and `NOTE_DONE` in the same cycle: toggle wins and `NOTE_DONE` is ignored.
  - Push and pop in the same cycle with the buffer full: legal; count unchanged.
  - `NOTE_DONE` outside P_RUN: ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `MEM_REQ`=0, `MEM_ADDR`=`START_ADDR`.
  - `NOTE_VALID`=0, `MODE`=0, `TONE`=0, `NOTE`=0.
  - `BPM`=`BPM_DEFAULT`, `PLAYING`=0, `SONG_END`=0.
- `RST` mid-fetch drops `MEM_REQ` immediately. A `MEM_ACK` arriving after reset release with no request outstanding is ignored.
- `MEM_REQ` falls the cycle after `MEM_ACK` is sampled; the next request can rise one cycle later.
- `NOTE_DONE` at cycle n → new note on outputs at n+1.
- Each preceding BPM_COMM adds 1 cycle.
- `PLAY_TOGGLE` at n → `PLAYING`/`NOTE_VALID` change at n+1.

## Configuration
- `NOTE_SEQ_LOOP_EN` defined:
  - End marker pulses `SONG_END`, resets the address and flushes the buffer.
  - Stays in P_RUN and continues from `START_ADDR`; `BPM` is not reset.
- Undefined: stop behaviour as described in Operation.

## Structure
- Shared package `audio_pkg`:
  - mode encodings NORMAL/STACCATO/SLURRED/BPM_COMM;
  - `END_WORD`=16'hC000;
  - default BPM 80;
  - field bit positions.
- Sub-module `note_fifo`: 2-entry, 16-bit synchronous FIFO with push, pop, full and empty, and a flush input.

## Test plan
- Reset, RAM = {0x0A25, 0x0C03, 0xC000}, `PLAY_TOGGLE` → after the first fetch, `TONE`=0x0A, `NOTE`=5, `NOTE_VALID`=1. `NOTE_DONE` → `TONE`=0x0C, `NOTE`=3 one cycle later. `NOTE_DONE` → `SONG_END` pulse, `PLAYING`=0.
- Word 0xC078 before a note → `BPM`=120 and the note is presented 1 cycle later than with no command.
- `MEM_ACK` delayed 10 cycles → `MEM_REQ`/`MEM_ADDR` stable throughout; `NOTE_VALID`=0 during underflow, then 1 on arrival.
- Pause mid-note, toggle again → same `TONE`/`NOTE` re-presented. `NOTE_DONE` in the pause/toggle cycle is ignored.
- `RST` asserted in F_WAIT → `MEM_REQ`=0 immediately, all outputs at reset values, late `MEM_ACK` ignored.
- With `NOTE_SEQ_LOOP_EN`, end marker → `SONG_END` pulse, `PLAYING` stays 1, next fetch at `START_ADDR`.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions: score word layout, mode encodings, end marker and default tempo.
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'b00,
        MODE_STACCATO = 2'b01,
        MODE_SLURRED  = 2'b10,
        MODE_BPM_COMM = 2'b11
    } mode_e;

    localparam logic [15:0] END_WORD    = 16'hC000;
    localparam int unsigned DEFAULT_BPM = 80;

    localparam int MODE_HI = 15, MODE_LO = 14;
    localparam int TONE_HI = 13, TONE_LO = 8;
    localparam int BPMF_HI = 7,  BPMF_LO = 0;
    localparam int NOTE_HI = 3,  NOTE_LO = 0;

    typedef enum logic       {F_IDLE, F_WAIT}         fetch_e;
    typedef enum logic [1:0] {P_STOP, P_RUN, P_PAUSE} play_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] tone;
        logic [3:0] note;
    } note_t;

endpackage

// File: rtl/note_fifo.sv
// 2-entry, 16-bit FIFO with flush. Popping while empty and pushing in the same
// cycle hands the incoming word straight through without storing it.
module note_fifo (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        full_o,
    output logic        empty_o
);
    logic [15:0] mem_q [2];
    logic        wr_q, rd_q;
    logic [1:0]  cnt_q, cnt_d;
    logic        do_push, do_pop;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !(empty_o && pop_i) && (!full_o || pop_i);
    assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    assign data_o  = empty_o ? data_i : mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) wr_q <= ~wr_q;
            if (do_pop)  rd_q <= ~rd_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Prefetches score words from RAM into a 2-entry buffer and plays them out one note at a time.
// Define NOTE_SEQ_LOOP_EN to restart from START_ADDR at the end marker instead of stopping.
module note_sequencer
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 23,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned BPM_DEFAULT = DEFAULT_BPM
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PLAY_TOGGLE,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [15:0]       MEM_DATA,
    input  logic              NOTE_DONE,
    output logic              NOTE_VALID,
    output logic [1:0]        MODE,
    output logic [5:0]        TONE,
    output logic [3:0]        NOTE,
    output logic [7:0]        BPM,
    output logic              PLAYING,
    output logic              SONG_END
);
    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
    localparam logic [7:0]        BPM_RST = 8'(BPM_DEFAULT);

    fetch_e            fstate_q, fstate_d;
    play_e             pstate_q, pstate_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d, endbuf_q, endbuf_d, need_q, need_d;
    logic              valid_q, valid_d, song_end_q, song_end_d;
    note_t             note_q, note_d;
    logic [7:0]        bpm_q, bpm_d;

    logic        ack_ok, push, pop_req, pop, flush, full, empty, is_cmd, is_end;
    logic [15:0] head;

    note_fifo u_fifo (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (push),
        .pop_i  (pop),
        .flush_i(flush),
        .data_i (MEM_DATA),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign ack_ok  = (fstate_q == F_WAIT) && MEM_ACK;
    assign push    = ack_ok && !discard_q;
    assign pop_req = ((pstate_q == P_STOP) && PLAY_TOGGLE) ||
                     ((pstate_q == P_RUN) && !PLAY_TOGGLE && (need_q || NOTE_DONE));
    assign pop     = pop_req && (!empty || push);
    assign is_cmd  = (head[MODE_HI:MODE_LO] == MODE_BPM_COMM);
    assign is_end  = (head == END_WORD);
    assign flush   = pop && is_end;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fstate_q   <= F_IDLE;
            pstate_q   <= P_STOP;
            addr_q     <= START_A;
            discard_q  <= 1'b0;
            endbuf_q   <= 1'b0;
            need_q     <= 1'b0;
            valid_q    <= 1'b0;
            note_q     <= '0;
            bpm_q      <= BPM_RST;
            song_end_q <= 1'b0;
        end else begin
            fstate_q   <= fstate_d;
            pstate_q   <= pstate_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            endbuf_q   <= endbuf_d;
            need_q     <= need_d;
            valid_q    <= valid_d;
            note_q     <= note_d;
            bpm_q      <= bpm_d;
            song_end_q <= song_end_d;
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        case (fstate_q)
            F_IDLE:  if (!full && !endbuf_q) fstate_d = F_WAIT;
            F_WAIT:  if (MEM_ACK) fstate_d = F_IDLE;
            default: fstate_d = F_IDLE;
        endcase

        pstate_d = pstate_q;
        case (pstate_q)
            P_STOP:  if (PLAY_TOGGLE) pstate_d = P_RUN;
            P_RUN:   if (PLAY_TOGGLE) pstate_d = P_PAUSE;
            P_PAUSE: if (PLAY_TOGGLE) pstate_d = P_RUN;
            default: pstate_d = P_STOP;
        endcase
`ifndef NOTE_SEQ_LOOP_EN
        if (flush) pstate_d = P_STOP;
`endif
    end

    always_comb begin
        addr_d     = addr_q;
        discard_d  = discard_q;
        endbuf_d   = endbuf_q;
        need_d     = need_q;
        valid_d    = valid_q;
        note_d     = note_q;
        bpm_d      = bpm_q;
        song_end_d = 1'b0;

        if (ack_ok) begin
            if (discard_q) begin
                discard_d = 1'b0;
                addr_d    = START_A;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        if (push && MEM_DATA == END_WORD) endbuf_d = 1'b1;
        // A fetch still in flight keeps its address on the bus; rewind once it lands.
        if (flush) begin
            endbuf_d = 1'b0;
            if (fstate_q == F_WAIT && !MEM_ACK) discard_d = 1'b1;
            else                                addr_d    = START_A;
        end

        if (pstate_q == P_RUN && PLAY_TOGGLE)   valid_d = 1'b0;
        if (pstate_q == P_PAUSE && PLAY_TOGGLE) valid_d = !need_q;

        if (pop_req) begin
            if (!pop) begin
                need_d  = 1'b1;
                valid_d = 1'b0;
            end else if (!is_cmd) begin
                note_d  = '{mode: head[MODE_HI:MODE_LO], tone: head[TONE_HI:TONE_LO],
                            note: head[NOTE_HI:NOTE_LO]};
                valid_d = 1'b1;
                need_d  = 1'b0;
            end else if (!is_end) begin
                bpm_d   = head[BPMF_HI:BPMF_LO];
                need_d  = 1'b1;
                valid_d = 1'b0;
            end else begin
                song_end_d = 1'b1;
                valid_d    = 1'b0;
`ifdef NOTE_SEQ_LOOP_EN
                need_d     = 1'b1;
`else
                need_d     = 1'b0;
                bpm_d      = BPM_RST;
`endif
            end
        end
    end

    assign MEM_REQ    = (fstate_q == F_WAIT);
    assign MEM_ADDR   = addr_q;
    assign NOTE_VALID = valid_q;
    assign MODE       = note_q.mode;
    assign TONE       = note_q.tone;
    assign NOTE       = note_q.note;
    assign BPM        = bpm_q;
    assign PLAYING    = (pstate_q == P_RUN);
    assign SONG_END   = song_end_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: queue-based reference model plus directed literal checks.
module tb_note_sequencer;
    localparam int AW = 4;
    localparam int START = 3;
    localparam int DEFBPM = 80;
    localparam int S_STOP = 0, S_RUN = 1, S_PAUSE = 2;

    logic        CLK = 0, RST = 0, PLAY_TOGGLE = 0, MEM_ACK = 0, NOTE_DONE = 0;
    logic [15:0] MEM_DATA = 0;
    logic        MEM_REQ, NOTE_VALID, PLAYING, SONG_END;
    logic [AW-1:0] MEM_ADDR;
    logic [1:0]  MODE;
    logic [5:0]  TONE;
    logic [3:0]  NOTE;
    logic [7:0]  BPM;

    note_sequencer #(.ADDR_W(AW), .START_ADDR(START), .BPM_DEFAULT(DEFBPM)) dut (
        .CLK(CLK), .RST(RST), .PLAY_TOGGLE(PLAY_TOGGLE), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .NOTE_DONE(NOTE_DONE), .NOTE_VALID(NOTE_VALID),
        .MODE(MODE), .TONE(TONE), .NOTE(NOTE), .BPM(BPM), .PLAYING(PLAYING), .SONG_END(SONG_END)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;
    logic [15:0] ram [16];

    // reference model state
    bit          m_req, m_disc, m_want, m_valid, m_end;
    int          m_addr, m_pst;
    logic [15:0] m_q[$];
    logic [1:0]  m_mode;
    logic [5:0]  m_tone;
    logic [3:0]  m_note;
    logic [7:0]  m_bpm;
    int          lat_cnt, lat_lo, lat_hi;
    bit          force_ack, chk_en;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_disc = 0; m_want = 0; m_valid = 0; m_end = 0;
        m_addr = START; m_pst = S_STOP; m_q.delete();
        m_mode = 0; m_tone = 0; m_note = 0; m_bpm = 8'(DEFBPM);
    endtask

    function automatic bit has_end();
        foreach (m_q[i]) if (m_q[i] == 16'hC000) return 1;
        return 0;
    endfunction

    task automatic model_step(input bit tog, input bit done, input bit ack, input logic [15:0] data);
        bit req0, end0, popreq, flush;
        int sz0;
        logic [15:0] w;
        req0 = m_req; sz0 = m_q.size(); end0 = has_end(); flush = 0;
        popreq = (m_pst == S_STOP && tog) || (m_pst == S_RUN && !tog && (m_want || done));
        m_end = 0;
        if (tog) begin
            if (m_pst == S_STOP) m_pst = S_RUN;
            else if (m_pst == S_RUN) begin m_pst = S_PAUSE; m_valid = 0; end
            else begin m_pst = S_RUN; m_valid = !m_want; end
        end
        if (req0 && ack && !m_disc) m_q.push_back(data);
        if (popreq) begin
            if (m_q.size() == 0) begin
                m_want = 1; m_valid = 0;
            end else begin
                w = m_q.pop_front();
                if (w[15:14] != 2'b11) begin
                    m_mode = w[15:14]; m_tone = w[13:8]; m_note = w[3:0];
                    m_valid = 1; m_want = 0;
                end else if (w[7:0] != 0) begin
                    m_bpm = w[7:0]; m_want = 1; m_valid = 0;
                end else begin
                    m_end = 1; m_valid = 0; flush = 1; m_q.delete();
`ifdef NOTE_SEQ_LOOP_EN
                    m_want = 1;
`else
                    m_want = 0; m_bpm = 8'(DEFBPM); m_pst = S_STOP;
`endif
                end
            end
        end
        if (req0 && ack) begin
            m_req = 0;
            if (m_disc) begin m_disc = 0; m_addr = START; end
            else m_addr = (m_addr + 1) % (1 << AW);
        end else if (!req0 && sz0 < 2 && !end0) begin
            m_req = 1;
            lat_cnt = int'($urandom_range(lat_hi, lat_lo));
        end
        if (flush) begin
            if (req0 && !ack) m_disc = 1;
            else m_addr = START;
        end
    endtask

    // one clock: drive inputs, let the DUT sample them, advance the model, land at edge+1
    task automatic step(input bit tog, input bit done);
        PLAY_TOGGLE = tog; NOTE_DONE = done;
        if (force_ack || (m_req && lat_cnt == 0)) begin
            MEM_ACK = 1;
            MEM_DATA = force_ack ? 16'h0A3F : ram[m_addr];
        end else begin
            MEM_ACK = 0;
            MEM_DATA = 16'($urandom);
            if (m_req) lat_cnt--;
        end
        @(posedge CLK);
        if (RST) model_reset();
        else model_step(tog, done, MEM_ACK, MEM_DATA);
        #1;
        force_ack = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0);
    endtask

    task automatic do_reset();
        RST = 1;
        model_reset();
        #1;
        chk("rst_MEM_REQ", int'(MEM_REQ), 0);
        chk("rst_MEM_ADDR", int'(MEM_ADDR), START);
        chk("rst_NOTE_VALID", int'(NOTE_VALID), 0);
        chk("rst_MODE_TONE_NOTE", int'({MODE, TONE, NOTE}), 0);
        chk("rst_BPM", int'(BPM), 80);
        chk("rst_PLAYING", int'(PLAYING), 0);
        chk("rst_SONG_END", int'(SONG_END), 0);
        repeat (2) step(0, 0);
        RST = 0;
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("MEM_REQ", int'(MEM_REQ), int'(m_req));
            if (m_req) chk("MEM_ADDR", int'(MEM_ADDR), m_addr);
            chk("NOTE_VALID", int'(NOTE_VALID), int'(m_valid));
            if (m_valid) chk("MODE_TONE_NOTE", int'({MODE, TONE, NOTE}), int'({m_mode, m_tone, m_note}));
            chk("BPM", int'(BPM), int'(m_bpm));
            chk("PLAYING", int'(PLAYING), int'(m_pst == S_RUN));
            chk("SONG_END", int'(SONG_END), int'(m_end));
        end
    end

    initial begin
        int uf, unstable;
        foreach (ram[i]) ram[i] = 16'h0000;
        lat_lo = 1; lat_hi = 1; force_ack = 0;
        model_reset();
        chk_en = 1;
        #1;

        // basic song
        ram[3] = 16'h0A25; ram[4] = 16'h0C03; ram[5] = 16'hC000;
        do_reset();
        idle(8);
        step(1, 0);
        chk("t1_playing", int'(PLAYING), 1);
        chk("t1_valid", int'(NOTE_VALID), 1);
        chk("t1_tone", int'(TONE), 'h0A);
        chk("t1_note", int'(NOTE), 5);
        idle(6);
        step(0, 1);
        chk("t1_tone2", int'(TONE), 'h0C);
        chk("t1_note2", int'(NOTE), 3);
        idle(2);
        step(0, 1);
        chk("t1_song_end", int'(SONG_END), 1);
`ifdef NOTE_SEQ_LOOP_EN
        chk("t1_playing_end", int'(PLAYING), 1);
`else
        chk("t1_playing_end", int'(PLAYING), 0);
`endif
        chk("t1_valid_end", int'(NOTE_VALID), 0);
        step(0, 0);
        chk("t1_song_end_pulse", int'(SONG_END), 0);

        // tempo command ahead of a note, then pause/resume
        ram[3] = 16'hC078; ram[4] = 16'h0A25; ram[5] = 16'h0C03; ram[6] = 16'hC000;
        do_reset();
        idle(8);
        step(1, 0);
        chk("t2_bpm", int'(BPM), 120);
        chk("t2_valid_gap", int'(NOTE_VALID), 0);
        step(0, 0);
        chk("t2_valid", int'(NOTE_VALID), 1);
        chk("t2_tone", int'(TONE), 'h0A);
        idle(3);
        step(1, 1);
        chk("t2_pause_playing", int'(PLAYING), 0);
        chk("t2_pause_valid", int'(NOTE_VALID), 0);
        step(0, 1);
        step(1, 0);
        chk("t2_resume_valid", int'(NOTE_VALID), 1);
        chk("t2_resume_note", int'({TONE, NOTE}), int'({6'h0A, 4'd5}));
        step(0, 1);
        chk("t2_next_note", int'(NOTE), 3);

        // slow memory: underflow until the first word lands
        ram[3] = 16'h0A25; ram[4] = 16'h0C03; ram[5] = 16'hC000;
        lat_lo = 10; lat_hi = 10;
        do_reset();
        step(1, 0);
        uf = 0; unstable = 0;
        for (int i = 0; i < 30 && !NOTE_VALID; i++) begin
            if (MEM_REQ !== 1'b1 || int'(MEM_ADDR) != START) unstable++;
            uf++;
            step(0, 0);
        end
        chk("t3_underflow_cycles", uf, 11);
        chk("t3_req_stable", unstable, 0);
        chk("t3_arrival_tone", int'(TONE), 'h0A);

        // reset in the middle of a fetch, then a stray ack
        for (int i = 0; i < 20 && !m_req; i++) step(0, 0);
        chk("t4_fetch_pending", int'(m_req), 1);
        step(0, 0);
        lat_lo = 1; lat_hi = 1;
        do_reset();
        force_ack = 1;
        step(0, 0);
        idle(8);
        step(1, 0);
        chk("t4_note_after_rst", int'({TONE, NOTE}), int'({6'h0A, 4'd5}));

        // randomized songs
        for (int s = 0; s < 6; s++) begin
            foreach (ram[i]) begin
                if ($urandom_range(9, 0) < 2) ram[i] = {8'hC0, 8'($urandom_range(255, 1))};
                else ram[i] = {2'($urandom_range(2, 0)), 14'($urandom)};
            end
            if (s != 2) ram[$urandom_range(15, 0)] = 16'hC000;
            lat_lo = 0; lat_hi = int'($urandom_range(4, 0));
            if (s % 2 == 1) do_reset();
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(299, 0) == 0) do_reset();
                else step(($urandom_range(39, 0) == 0) || (m_pst == S_STOP && $urandom_range(9, 0) == 0),
                          $urandom_range(3, 0) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
